// File: rtl/lfsr_run_ctrl.sv
// Run controller for the LFSR / sequence-detector datapath: seeds the LFSR, gates
// shifting for a bounded number of cycles, counts detections and optionally pauses after hits.
module lfsr_run_ctrl #(
    parameter int CNT_W     = 11,
    parameter int DET_W     = 8,
    parameter int PAUSE_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             pause_en,
    input  logic [CNT_W-1:0] run_len,
    input  logic             seq_detected,
    input  logic             max_tick,
    output logic             seed_load,
    output logic             sh_en,
    output logic             busy,
    output logic             done,
    output logic             ended_by_tick,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [DET_W-1:0] det_cnt
);

    localparam int PW = (PAUSE_CYC > 1) ? $clog2(PAUSE_CYC) : 1;
    localparam logic [PW-1:0] PAUSE_LAST = PW'(PAUSE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d, cyc_inc;
    logic [DET_W-1:0] det_q, det_d;
    logic             ebt_q, ebt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             pe_q, pe_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic             seed_q, seed_d;
    logic             sh_q, sh_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        det_d   = det_q;
        ebt_d   = ebt_q;
        len_d   = len_q;
        pe_d    = pe_q;
        pcnt_d  = pcnt_q;
        cyc_inc = cyc_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cyc_d   = '0;
                    det_d   = '0;
                    ebt_d   = 1'b0;
                end
            end
            S_LOAD: begin
                len_d   = run_len;
                pe_d    = pause_en;
                state_d = abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                // The shift in this cycle already happened (sh_en was high), so it is
                // counted even when the run is aborted or ends here.
                cyc_d = cyc_inc;
                if (seq_detected && (det_q != '1)) begin
                    det_d = det_q + 1'b1;
                end
                if (abort) begin
                    state_d = S_IDLE;
                end else if (max_tick) begin
                    state_d = S_DONE;
                    ebt_d   = 1'b1;
                end else if (cyc_inc == len_q) begin
                    // len_q == 0 matches after the counter wraps: 2^CNT_W cycles
                    state_d = S_DONE;
                end else if (seq_detected && pe_q) begin
                    state_d = S_PAUSE;
                    pcnt_d  = '0;
                end
            end
            S_PAUSE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (pcnt_q == PAUSE_LAST) begin
                    state_d = S_RUN;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they align with the state register.
        seed_d = (state_d == S_LOAD);
        sh_d   = (state_d == S_RUN);
        busy_d = (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_PAUSE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            det_q   <= '0;
            ebt_q   <= 1'b0;
            len_q   <= '0;
            pe_q    <= 1'b0;
            pcnt_q  <= '0;
            seed_q  <= 1'b0;
            sh_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            det_q   <= det_d;
            ebt_q   <= ebt_d;
            len_q   <= len_d;
            pe_q    <= pe_d;
            pcnt_q  <= pcnt_d;
            seed_q  <= seed_d;
            sh_q    <= sh_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign seed_load     = seed_q;
    assign sh_en         = sh_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign ended_by_tick = ebt_q;
    assign cycle_cnt     = cyc_q;
    assign det_cnt       = det_q;

endmodule

// File: doc/lfsr_run_ctrl.md
Name: lfsr_run_ctrl

Overview:
Run controller that sequences the 22-bit LFSR / sequence-detector datapath. It drives the LFSR seed load and shift enable, and bounds each run to a programmable cycle count. It counts sequence detections, optionally pausing shifting after each hit. It sits between software-style start/abort controls and the LFSR top level, replacing a hard-tied shift enable.

Parameters:
CNT_W, 11, width of run-cycle counter and run_len input
DET_W, 8, width of detection counter (saturating)
PAUSE_CYC, 4, cycles sh_en is held low after a detection when pause_en=1 (must be >=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a run; sampled only in IDLE
abort  input  1  terminate the current run immediately; highest priority
pause_en  input  1  1 = pause shifting for PAUSE_CYC cycles after each detection; sampled in LOAD
run_len  input  CNT_W  number of shift cycles per run; sampled in LOAD; 0 is treated as 2^CNT_W
seq_detected  input  1  detector hit from datapath, valid in the cycle it is asserted
max_tick  input  1  LFSR full-period tick from datapath
seed_load  output  1  one-cycle pulse; datapath reloads its seed
sh_en  output  1  LFSR shift enable
busy  output  1  high in LOAD, RUN and PAUSE
done  output  1  one-cycle pulse at end of a completed run (not asserted on abort)
ended_by_tick  output  1  1 if the last run ended on max_tick rather than run_len
cycle_cnt  output  CNT_W  shift cycles executed in the current/last run
det_cnt  output  DET_W  detections in the current/last run, saturating at all-ones

Behaviour:
- All outputs are registered. Reset (rst_n=0, asynchronous) forces state IDLE and every output to 0.
- States: IDLE, LOAD, RUN, PAUSE, DONE.
- IDLE: sh_en=0, busy=0. start=1 -> LOAD on the next edge. Counters hold their last-run values.
- LOAD, one cycle: seed_load=1, busy=1, sh_en=0. Clears cycle_cnt, det_cnt and ended_by_tick. Latches run_len and pause_en. Next state is RUN.
- RUN: sh_en=1 and cycle_cnt increments every cycle.
  - If seq_detected=1, det_cnt increments; it saturates at 2^DET_W-1.
  - Exit to DONE when the increment makes cycle_cnt equal to the latched run_len. This gives exactly run_len sh_en-high cycles.
  - Exit to DONE when max_tick=1. ended_by_tick is set to 1.
  - Otherwise, if seq_detected=1 and the latched pause_en=1, go to PAUSE.
- PAUSE: sh_en=0, and cycle_cnt does not increment. An internal counter runs for PAUSE_CYC cycles, then the state returns to RUN. seq_detected is ignored in PAUSE.
- DONE, one cycle: done=1, sh_en=0, busy=0. Next state is IDLE. start in DONE is ignored.
- Priority order per cycle: abort > end-of-run (run_len or max_tick) > pause entry.
  - A detection in the final run cycle is still counted. The state goes to DONE, not PAUSE.
  - If max_tick and the run_len terminal count coincide, ended_by_tick=1.
- abort=1 in LOAD, RUN or PAUSE: next state is IDLE and sh_en=0 on the next edge. There is no done pulse. Counters freeze at their current values. abort in IDLE or DONE has no effect.
- start while busy is ignored. A start held high through DONE begins a new run only from IDLE, so at least 1 IDLE cycle separates runs.
- run_len=0 runs 2^CNT_W cycles: cycle_cnt wraps to 0 at the terminal count, which is the end condition.
- Reset asserted mid-run returns the block to IDLE with all outputs 0 asynchronously.

Test Plan:
- Reset, then start=1 for 1 cycle with run_len=10 and pause_en=0. Required: seed_load pulses 1 cycle, sh_en is high for exactly 10 cycles, then done pulses once. Result: cycle_cnt=10, det_cnt=0, ended_by_tick=0.
- run_len=20, pause_en=1, seq_detected pulsed at RUN cycles 3 and 8. Required: sh_en drops for 4 cycles after each hit. Result: det_cnt=2, cycle_cnt=20, total busy cycles = 1+20+8.
- run_len=100, max_tick pulsed at RUN cycle 37. Required: done at the next edge, cycle_cnt=37, ended_by_tick=1.
- abort at RUN cycle 5, then start during RUN and DONE of a second run. Required: first run returns to IDLE with no done pulse and cycle_cnt=5. The starts while busy are ignored, and no extra run is launched.
- DET_W=2 with seq_detected held high for 6 RUN cycles and pause_en=0. Required: det_cnt saturates at 3.
- seq_detected and max_tick coincide on the last cycle with pause_en=1. Required: det_cnt increments, the state goes to DONE (no PAUSE), and ended_by_tick=1. Also assert rst_n=0 mid-run and check all outputs go to 0 immediately.
